// File: rtl/rc_pulse_capture.sv
`timescale 1ns/1ps
// RC PWM pulse-width capture: synchronizes and deglitches the raw input, measures
// each high time in clk cycles, and flags rejected pulses and loss of signal.
module rc_pulse_capture #(
  parameter int FILTER_LEN    = 4,
  parameter int MIN_PULSE     = 800,
  parameter int MAX_PULSE     = 2200,
  parameter int FRAME_TIMEOUT = 25000,
  parameter int WIDTH_BITS    = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  rc_in_i,
  output logic                  filtered_o,
  output logic [WIDTH_BITS-1:0] pulse_width_o,
  output logic                  pulse_valid_o,
  output logic                  pulse_error_o,
  output logic                  signal_lost_o
);

  localparam int TO_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [WIDTH_BITS-1:0] MIN_W   = WIDTH_BITS'(MIN_PULSE);
  localparam logic [WIDTH_BITS-1:0] MAX_W   = WIDTH_BITS'(MAX_PULSE);
  localparam logic [TO_W-1:0]       TO_MAX  = TO_W'(FRAME_TIMEOUT);
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(FRAME_TIMEOUT - 1);
  localparam logic [3:0]            FLT_LAST = 4'(FILTER_LEN - 1);

  if (MAX_PULSE + 1 >= (1 << WIDTH_BITS)) begin : g_width_check
    $error("rc_pulse_capture: MAX_PULSE+1 does not fit in WIDTH_BITS");
  end
  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_filter_check
    $error("rc_pulse_capture: FILTER_LEN must be 2..15");
  end

  typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH, OVERLONG} state_t;

  state_t                state, state_d;
  logic [1:0]            sync_q;
  logic [3:0]            flt_cnt;
  logic                  settled_q;
  logic [WIDTH_BITS-1:0] width_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  arm_ok, load_first, count_up, accept, reject;

  // Input synchronizer; sync_q[1] is the first value safe to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], rc_in_i};
  end

  // Symmetric run-length filter: same latency for both edges keeps widths exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt    <= 4'd0;
      filtered_o <= 1'b0;
    end else if (sync_q[1] == filtered_o) begin
      flt_cnt <= 4'd0;
    end else if (flt_cnt == FLT_LAST) begin
      filtered_o <= sync_q[1];
      flt_cnt    <= 4'd0;
    end else begin
      flt_cnt <= flt_cnt + 4'd1;
    end
  end

  // The pipeline still holds reset zeros for a cycle; ARM must not trust it yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) settled_q <= 1'b0;
    else        settled_q <= 1'b1;
  end

  assign arm_ok = settled_q && !filtered_o && !sync_q[0] && !sync_q[1] && (flt_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARM;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ARM:       if (arm_ok) state_d = WAIT_RISE;
      WAIT_RISE: if (filtered_o) state_d = HIGH;
      HIGH: begin
        if (!filtered_o)             state_d = WAIT_RISE;
        else if (width_cnt == MAX_W) state_d = OVERLONG;
      end
      OVERLONG:  if (!filtered_o) state_d = WAIT_RISE;
      default:   state_d = ARM;
    endcase
    if (!enable_i) state_d = ARM;
  end

  always_comb begin
    load_first = 1'b0;
    count_up   = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    if (enable_i) begin
      load_first = (state == WAIT_RISE) && filtered_o;
      count_up   = (state == HIGH) && filtered_o;
      accept     = (state == HIGH) && !filtered_o && (width_cnt >= MIN_W);
      reject     = (state == HIGH) && (filtered_o ? (width_cnt == MAX_W) : (width_cnt < MIN_W));
    end
  end

  // Counting stops once OVERLONG is entered, so MAX_PULSE+1 is the ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          width_cnt <= '0;
    else if (!enable_i)  width_cnt <= '0;
    else if (load_first) width_cnt <= WIDTH_BITS'(1);
    else if (count_up)   width_cnt <= width_cnt + WIDTH_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_width_o <= '0;
      pulse_valid_o <= 1'b0;
      pulse_error_o <= 1'b0;
    end else begin
      pulse_valid_o <= accept;
      pulse_error_o <= reject;
      if (accept) pulse_width_o <= width_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_cnt <= '0;
    else if (!enable_i)        to_cnt <= '0;
    else if (accept)           to_cnt <= '0;
    else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
  end

  // Sticky until a valid pulse: covers both post-reset and post-timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 signal_lost_o <= 1'b1;
    else if (!enable_i)         signal_lost_o <= 1'b1;
    else if (accept)            signal_lost_o <= 1'b0;
    else if (to_cnt == TO_LAST) signal_lost_o <= 1'b1;
  end

endmodule

// File: doc/rc_pulse_capture.md
RC_PULSE_CAPTURE -- requirements
Module: rc_pulse_capture

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- FILTER_LEN, 4: consecutive equal synchronized samples needed to change the filtered level (2..15).
- MIN_PULSE, 800: shortest accepted high time, in clk cycles.
- MAX_PULSE, 2200: longest accepted high time, in clk cycles.
- FRAME_TIMEOUT, 25000: clk cycles without a valid pulse before the signal is declared lost.
- WIDTH_BITS, 12: width of pulse_width_o.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: single clock, 1 MHz.
- rst_n, in, 1: reset, asynchronous, active-low.
- enable_i, in, 1: capture enable.
- rc_in_i, in, 1: raw asynchronous RC PWM input.
- filtered_o, out, 1: synchronized, deglitched input level.
- pulse_width_o, out, WIDTH_BITS: last accepted high time in cycles.
- pulse_valid_o, out, 1: one-cycle strobe when pulse_width_o updates.
- pulse_error_o, out, 1: one-cycle strobe when a pulse is rejected.
- signal_lost_o, out, 1: level, high when no valid pulse was seen within FRAME_TIMEOUT.

Function
REQ-003 rc_in_i SHALL pass through a 2-flop synchronizer before any other use.
REQ-004 filtered_o SHALL change only after FILTER_LEN consecutive synchronized samples of the opposite value.
REQ-005 Raw-to-filtered latency SHALL be FILTER_LEN+2 cycles, identical for rising and falling edges, so that clean pulse widths are preserved exactly.
REQ-006 A glitch shorter than FILTER_LEN cycles SHALL NOT change filtered_o.
REQ-007 The FSM SHALL have four states:
- ARM: wait for filtered low, then go to WAIT_RISE. This discards any pulse already in progress.
- WAIT_RISE: on a filtered rising edge, load the width counter to 1 and go to HIGH.
- HIGH: increment the counter each cycle while filtered is high; the falling edge ends measurement.
- OVERLONG: wait for filtered low, then go to WAIT_RISE.
REQ-008 Measured width SHALL equal the number of cycles filtered_o was high.
REQ-009 On the falling edge in HIGH, with MIN_PULSE <= width <= MAX_PULSE:
- pulse_width_o SHALL load width on the following clock edge.
- pulse_valid_o SHALL pulse high for exactly that cycle.
- The FSM SHALL go to WAIT_RISE.
REQ-010 On the falling edge in HIGH, with width < MIN_PULSE:
- pulse_error_o SHALL strobe once.
- pulse_width_o SHALL hold its value.
- The FSM SHALL go to WAIT_RISE.
REQ-011 When the counter reaches MAX_PULSE+1 while in HIGH, pulse_error_o SHALL strobe once and the FSM SHALL go to OVERLONG. No further error SHALL be raised for that pulse.
REQ-012 The width counter SHALL never wrap. MAX_PULSE+1 SHALL be less than 2^WIDTH_BITS; this is checked at elaboration.
REQ-013 pulse_valid_o and pulse_error_o SHALL never be high in the same cycle.
REQ-014 The timeout counter behaves as follows:
- It SHALL clear on every pulse_valid_o.
- It SHALL otherwise increment each cycle, saturating at FRAME_TIMEOUT.
- signal_lost_o SHALL be high while the counter equals FRAME_TIMEOUT.
- signal_lost_o SHALL clear in the same cycle pulse_valid_o is asserted.
REQ-015 While enable_i is low:
- The FSM SHALL be forced to ARM.
- The width and timeout counters SHALL be cleared.
- Strobes SHALL be 0.
- signal_lost_o SHALL be 1.
- pulse_width_o SHALL hold its value.
- The synchronizer and filter SHALL keep running.
REQ-016 When enable_i rises, capture SHALL resume from ARM. The first accepted pulse SHALL have its rising edge after the enable.

Reset
REQ-017 rst_n low SHALL asynchronously set the following, with release synchronous to clk:
- Synchronizer, filter and filtered_o to 0.
- FSM to ARM.
- All counters to 0.
- pulse_width_o to 0.
- pulse_valid_o and pulse_error_o to 0.
- signal_lost_o to 1.
REQ-018 A reset in the middle of a pulse SHALL discard that pulse: no strobe for it, and the FSM re-arms only after filtered goes low.

Verification
REQ-019 Clean pulse: 1500-cycle high every 20000 cycles, enable=1 -> pulse_valid_o once per frame, pulse_width_o=1500, and signal_lost_o falls at the first strobe.
REQ-020 Boundaries: pulses of 799, 800, 2200 and 2201 cycles ->
- 799: error strobe, width held.
- 800: valid, width=800.
- 2200: valid, width=2200.
- 2201: one error strobe at counter 2201, no valid.
REQ-021 Glitches: a 3-cycle high spike and a 3-cycle low notch inside a 1500-cycle pulse -> filtered_o unchanged by either, and width=1500 reported.
REQ-022 Timeout: one valid 1500-cycle pulse, then rc_in_i held low -> signal_lost_o rises exactly 25000 cycles after pulse_valid_o, and pulse_width_o stays 1500.
REQ-023 Reset mid-pulse: assert rst_n low 600 cycles into a 1500-cycle high, release while still high -> no strobe for that pulse, the next full pulse is reported correctly, and all outputs held their reset values during reset.
REQ-024 Enable gating: drop enable_i during a pulse, raise it while rc_in_i is still high -> the partial pulse is ignored, signal_lost_o=1 while disabled, and the next pulse is accepted.
